program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Host-side feeder for the pipelined CPU's instruction-load port. Accepts a program from a host
//  over a valid/ready stream and buffers it. It then holds the CPU in reset, bursts the words into
//  the CPU's LoadInstructions/Instruction inputs on consecutive cycles, and releases the CPU to run.
//  Burst must be gap-free: the CPU load address counter advances every clk.
// PARAMETERS
//  DEPTH      32  max program length in words (= CPU instruction memory depth)
//  CNT_W      6   width of word counter; must hold 0..DEPTH
//  RST_CYC    2   cycles cpu_Reset is held before and after the burst (>=1)
// PORTS
//  clk               in   1   sole clock, rising edge
//  Reset_n           in   1   asynchronous, active-low reset
//  in_valid          in   1   host word valid
//  in_ready          out  1   loader can accept a word
//  in_data           in   32  host instruction word
//  in_last           in   1   qualifies in_data as final program word
//  reload            in   1   1-cycle pulse in RUN: discard program, return to FILL
//  cpu_Reset         out  1   drives CPU Reset (active-high)
//  LoadInstructions  out  1   drives CPU LoadInstructions
//  Instruction       out  32  drives CPU Instruction
//  busy              out  1   1 in PRE, BURST, POST
//  done              out  1   1 in RUN (CPU executing)
//  word_count        out  CNT_W  words accepted in current program
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=FILL, cpu_Reset=1, LoadInstructions=0, Instruction=0,
//   busy=0, done=0, word_count=0; buffer contents don't-care. All outputs are registered
//   except in_ready.
//  in_ready = (state==FILL) && (word_count<DEPTH); combinational. It is 1 out of reset.
//  Transfer occurs on a clk edge with in_valid && in_ready: buf[word_count]<=in_data,
//   word_count++.
//  FSM: FILL -> PRE -> BURST -> POST -> RUN -> (reload) FILL.
//  FILL: cpu_Reset=1. Leave to PRE on the edge that transfers a word with in_last=1, or
//   that transfers word number DEPTH (forced last; in_last ignored). Minimum program = 1 word.
//  PRE: cpu_Reset=1 for exactly RST_CYC cycles, clearing CPU PC and load counter.
//  BURST: exactly word_count cycles. In burst cycle i (i=0..word_count-1): cpu_Reset=0,
//   LoadInstructions=1, Instruction=buf[i]. The first burst cycle is also the first
//   cycle with cpu_Reset=0, so CPU load address i receives buf[i].
//  POST: LoadInstructions=0, Instruction=0, cpu_Reset=1 for RST_CYC cycles. This clears
//   the pipeline and PC disturbed during loading.
//  RUN: cpu_Reset=0, done=1, in_ready=0. A reload pulse sets cpu_Reset=1 and done=0 next
//   cycle, clears word_count, and enters FILL. reload is ignored in all other states.
//  Host words offered outside FILL are not accepted (in_ready=0) and not lost by the host.
//  Instruction is 0 whenever LoadInstructions=0.
//  Reset_n asserted mid-BURST: immediate return to reset values. The CPU is left in
//   reset; the partial load is abandoned and the host must resend the whole program.
//  Latency: last-word accept edge -> first LoadInstructions cycle = RST_CYC+1 edges;
//   done rises 2*RST_CYC+word_count+1 edges after last accept.
// TESTING
//  1. Push 4 words 0x20010005,0x20020003,0x00221820,0xAC030000, last on 4th.
//     Expect cpu_Reset=1 for 2 cycles, then 4 consecutive LoadInstructions cycles
//     carrying those words in order, then 2 reset cycles, then done=1, and
//     WB `out` of CPU shows 5,3,8.
//  2. Single word with in_last=1 -> BURST lasts exactly 1 cycle; word_count=1.
//  3. Push 32 words, none with in_last -> in_ready falls after the 32nd; word 33 is held
//     by the host. The burst is 32 cycles, buf[31] is on the last cycle, and done=1 follows.
//  4. Randomly toggle in_valid (gaps of 0-3 cycles) over 10 words -> burst is still
//     10 contiguous cycles, with data order matching push order.
//  5. Reset_n=0 during burst cycle 2 -> outputs at reset values immediately. Reload
//     3 words -> correct burst from CPU address 0.
//  6. In RUN pulse reload, push new 2-word program -> cpu_Reset=1 from the cycle after
//     reload. New program runs; in_valid offered during RUN before reload is not accepted.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: host-side feeder for the pipelined CPU's instruction-load port.
//
// Collects a program from the host over a valid/ready stream into a local buffer. Once the
// last word arrives it holds the CPU in reset, bursts the buffered words into the CPU's
// LoadInstructions/Instruction inputs on consecutive cycles, holds reset again to flush
// the pipeline, then releases the CPU to run until a reload pulse restarts the sequence.
//
// Ports:
//   clk              - sole clock, rising edge
//   Reset_n          - asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last - host program stream (in_last marks final word)
//   reload           - one-cycle pulse in RUN: discard program and return to FILL
//   cpu_Reset        - CPU reset, active-high
//   LoadInstructions - CPU instruction-load strobe
//   Instruction      - CPU instruction-load data (0 whenever LoadInstructions is 0)
//   busy             - 1 while loading (PRE, BURST, POST)
//   done             - 1 while the CPU runs
//   word_count       - words accepted into the current program
module program_loader #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned RST_CYC = 2
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic             reload,
  output logic             cpu_Reset,
  output logic             LoadInstructions,
  output logic [31:0]      Instruction,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {StFill, StPre, StBurst, StPost, StRun} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] word_count_q;
  logic [CNT_W-1:0] cyc_q;        // cycle index within PRE, BURST or POST
  logic             cpu_reset_q;
  logic             load_q;
  logic [31:0]      instr_q;
  logic             busy_q;
  logic             done_q;

  logic [31:0]      buf_mem [DEPTH];

  logic             accept;
  logic             last_accept;
  logic             rst_last;
  logic             burst_last;
  logic [IdxW-1:0]  wr_idx;
  logic [IdxW-1:0]  nxt_rd_idx;

  assign in_ready    = (state_q == StFill) && (word_count_q < CNT_W'(DEPTH));
  assign accept      = in_valid && in_ready;
  // Word number DEPTH ends the program whether or not in_last is set.
  assign last_accept = accept && (in_last || (word_count_q == CNT_W'(DEPTH - 1)));
  assign rst_last    = (cyc_q == CNT_W'(RST_CYC - 1));
  assign burst_last  = (cyc_q == (word_count_q - CNT_W'(1)));
  assign wr_idx      = word_count_q[IdxW-1:0];
  assign nxt_rd_idx  = IdxW'(cyc_q + CNT_W'(1));

  // Program buffer needs no reset; only words below word_count are ever read.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StFill;
      word_count_q <= '0;
      cyc_q        <= '0;
      cpu_reset_q  <= 1'b1;
      load_q       <= 1'b0;
      instr_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        StFill: begin
          if (accept) begin
            word_count_q <= word_count_q + CNT_W'(1);
          end
          if (last_accept) begin
            state_q <= StPre;
            cyc_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StPre: begin
          if (rst_last) begin
            // First burst cycle is also the first cycle out of reset, so the CPU's
            // load address counter starts at 0 together with buf[0].
            state_q     <= StBurst;
            cyc_q       <= '0;
            cpu_reset_q <= 1'b0;
            load_q      <= 1'b1;
            instr_q     <= buf_mem[0];
          end else begin
            cyc_q <= cyc_q + CNT_W'(1);
          end
        end
        StBurst: begin
          if (burst_last) begin
            state_q     <= StPost;
            cyc_q       <= '0;
            cpu_reset_q <= 1'b1;
            load_q      <= 1'b0;
            instr_q     <= '0;
          end else begin
            cyc_q   <= cyc_q + CNT_W'(1);
            instr_q <= buf_mem[nxt_rd_idx];
          end
        end
        StPost: begin
          if (rst_last) begin
            state_q     <= StRun;
            cyc_q       <= '0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            cyc_q <= cyc_q + CNT_W'(1);
          end
        end
        StRun: begin
          if (reload) begin
            state_q      <= StFill;
            word_count_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= StFill;
        end
      endcase
    end
  end

  assign cpu_Reset        = cpu_reset_q;
  assign LoadInstructions = load_q;
  assign Instruction      = instr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign word_count       = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader. A queue holds the words pushed by the
// host; the expected output sequence after the last accept is derived from the phase lengths
// (RST_CYC reset cycles, one load cycle per word, RST_CYC reset cycles, then run).
module tb_program_loader;

  localparam int unsigned DEPTH   = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned RST_CYC = 2;

  logic             clk;
  logic             Reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             reload;
  logic             cpu_Reset;
  logic             LoadInstructions;
  logic [31:0]      Instruction;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] word_count;

  int n_tests;
  int n_fail;

  logic [31:0] prog[$];

  program_loader #(
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .RST_CYC(RST_CYC)
  ) dut (
    .clk             (clk),
    .Reset_n         (Reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .reload          (reload),
    .cpu_Reset       (cpu_Reset),
    .LoadInstructions(LoadInstructions),
    .Instruction     (Instruction),
    .busy            (busy),
    .done            (done),
    .word_count      (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // {cpu_Reset, LoadInstructions, busy, done, in_ready}
  function automatic logic [31:0] status();
    return {27'd0, cpu_Reset, LoadInstructions, busy, done, in_ready};
  endfunction

  localparam logic [31:0] StsFill0 = 32'b10001; // FILL, empty buffer
  localparam logic [31:0] StsHold  = 32'b10100; // PRE or POST
  localparam logic [31:0] StsLoad  = 32'b01100; // BURST
  localparam logic [31:0] StsRun   = 32'b00010; // RUN

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input logic [31:0] d, input logic last);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_prog(input int n, input bit use_last, input int max_gap);
    logic [31:0] d;
    prog.delete();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      d = $urandom;
      prog.push_back(d);
      push_word(d, use_last && (i == n - 1));
    end
  endtask

  // Walks the load sequence from the cycle after the last accept up to the first RUN cycle.
  // With noise set, host and reload inputs toggle randomly; none of them may have an effect.
  task automatic check_run(input bit noise);
    int n;
    int total;
    logic [31:0] exp_st;
    logic [31:0] exp_in;
    n = prog.size();
    total = 2 * RST_CYC + n + 1;
    for (int k = 1; k <= total; k++) begin
      if (k <= RST_CYC) begin
        exp_st = StsHold;
        exp_in = 32'd0;
      end else if (k <= RST_CYC + n) begin
        exp_st = StsLoad;
        exp_in = prog[k - RST_CYC - 1];
      end else if (k <= 2 * RST_CYC + n) begin
        exp_st = StsHold;
        exp_in = 32'd0;
      end else begin
        exp_st = StsRun;
        exp_in = 32'd0;
      end
      check($sformatf("status_k%0d_n%0d", k, n), status(), exp_st);
      check($sformatf("instr_k%0d_n%0d", k, n), Instruction, exp_in);
      if (k < total) begin
        if (noise) begin
          reload   = 1'($urandom_range(0, 1));
          in_valid = 1'($urandom_range(0, 1));
          in_last  = 1'($urandom_range(0, 1));
          in_data  = $urandom;
        end
        @(negedge clk);
      end
    end
    reload   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check($sformatf("wcount_n%0d", n), 32'(word_count), n);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_status", status(), StsFill0);
    check("reload_wcount", 32'(word_count), 32'd0);
    check("reload_instr", Instruction, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    n_tests  = 0;
    n_fail   = 0;
    Reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    reload   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_status", status(), StsFill0);
    check("rst_instr", Instruction, 32'd0);
    check("rst_wcount", 32'(word_count), 32'd0);
    Reset_n = 1'b1;
    @(negedge clk);

    // Fixed 4-word program.
    prog = '{32'h20010005, 32'h20020003, 32'h00221820, 32'hAC030000};
    for (int i = 0; i < 4; i++) push_word(prog[i], i == 3);
    check_run(1'b0);
    do_reload();

    // Single-word program.
    push_prog(1, 1'b1, 0);
    check_run(1'b1);
    do_reload();

    // Full buffer without in_last: word DEPTH ends the program.
    push_prog(DEPTH, 1'b0, 0);
    check_run(1'b1);

    // Word offered in RUN is held off until after reload, then becomes word 0.
    held = $urandom;
    in_valid = 1'b1;
    in_data  = held;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("run_hold_wcount", 32'(word_count), DEPTH);
      check("run_hold_status", status(), StsRun);
    end
    do_reload();
    prog.delete();
    prog.push_back(held);
    push_word(held, 1'b0);
    prog.push_back($urandom);
    push_word(prog[1], 1'b1);
    check_run(1'b1);
    do_reload();

    // 10 words with random gaps.
    push_prog(10, 1'b1, 3);
    check_run(1'b1);
    do_reload();

    // Async reset during burst cycle 2, then a fresh 3-word program.
    push_prog(5, 1'b1, 0);
    repeat (RST_CYC + 2) @(negedge clk);
    check("pre_rst_instr", Instruction, prog[2]);
    Reset_n = 1'b0;
    #1;
    check("midrst_status", status(), StsFill0);
    check("midrst_instr", Instruction, 32'd0);
    check("midrst_wcount", 32'(word_count), 32'd0);
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    push_prog(3, 1'b1, 1);
    check_run(1'b0);
    do_reload();

    // Random programs.
    for (int r = 0; r < 5; r++) begin
      push_prog($urandom_range(1, DEPTH), 1'b1, 2);
      check_run(1'b1);
      do_reload();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
